// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised raster timing generator. Produces H/V sync with
//             selectable polarity, an active-area flag, X/Y coordinates, a
//             linear active-pixel index, line/frame strobes and a frame
//             counter, advancing one position per enabled clock.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FW       = 16,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
  localparam int PW      = (H_ACTIVE * V_ACTIVE > 1) ? $clog2(H_ACTIVE * V_ACTIVE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          pixel,
  output logic [HW-1:0] h_pos,
  output logic [VW-1:0] v_pos,
  output logic [PW-1:0] p_count,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  // Position limits and region boundaries, sized to the counters. The
  // boundary constants carry one extra bit because a region may end exactly
  // at H_TOTAL / V_TOTAL, which does not fit in the coordinate width.
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW:0]   H_ACT_END = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   HS_START  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_END = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   VS_START  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic          h_wrap;
  logic          v_wrap;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic [HW:0]   h_ext;
  logic [VW:0]   v_ext;
  logic          pix_nxt;
  logic          hs_act_nxt;
  logic          vs_act_nxt;
  logic          origin_nxt;

  // Running count of active pixels already emitted in the current frame; it
  // supplies the next P_COUNT value without any multiplication.
  logic [PW-1:0] pix_run;

  // Next position and the region decode for that position, so every
  // registered output describes the same coordinate in the same cycle.
  always_comb begin
    h_wrap     = (h_pos == H_LAST);
    v_wrap     = (v_pos == V_LAST);
    h_nxt      = h_wrap ? '0 : h_pos + HW'(1);
    v_nxt      = v_pos;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : v_pos + VW'(1);
    end
    h_ext      = {1'b0, h_nxt};
    v_ext      = {1'b0, v_nxt};
    pix_nxt    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    hs_act_nxt = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_act_nxt = (v_ext >= VS_START) && (v_ext < VS_END);
    origin_nxt = h_wrap && v_wrap;
  end

  // Timing state: reset parks at the last position so the first enabled
  // edge enters (0,0); with EN low only the strobes are cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_pos       <= H_LAST;
      v_pos       <= V_LAST;
      pixel       <= 1'b0;
      p_count     <= '0;
      pix_run     <= '0;
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      h_pos       <= h_nxt;
      v_pos       <= v_nxt;
      pixel       <= pix_nxt;
      h_sync      <= hs_act_nxt ? HS_POL : ~HS_POL;
      v_sync      <= vs_act_nxt ? VS_POL : ~VS_POL;
      line_start  <= h_wrap;
      frame_start <= origin_nxt;
      if (origin_nxt) begin
        frame_cnt <= frame_cnt + FW'(1);
      end
      if (origin_nxt) begin
        p_count <= '0;
        pix_run <= PW'(1);
      end else if (pix_nxt) begin
        p_count <= pix_run;
        pix_run <= pix_run + PW'(1);
      end else begin
        p_count <= '0;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
`default_nettype wire
